lrn_window_engine: RTL and testbench
====================================

Name: lrn_window_engine

Overview:
- Data-side counterpart of the LRN address mapper. Accepts pixels returned from feature memory for the mapper's read stream and buffers them into a cross-channel sliding window.
- For each full window, computes the LRN value of the centre element and presents it for write-back.
- Drives the mapper's control inputs: full_flag, div_out_valid and normalized_window.

Parameters:
- DATA_WIDTH, 16, unsigned pixel width.
- WIN_DEPTH, 5, window depth in channels (odd, >=3).
- FRAC_BITS, 8, fractional bits of the result.
- K_CONST, 2, additive denominator constant (>=1).
- ALPHA_SHIFT, 4, right shift applied to the sum of squares (alpha = 2^-ALPHA_SHIFT).

Ports:
- core_clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- r_data_valid  in  1  memory read data valid; one push per cycle.
- r_data  in  DATA_WIDTH  memory read data.
- clear_window  in  1  flushes the window at a layer boundary.
- full_flag  out  1  window holds WIN_DEPTH entries.
- div_out_valid  out  1  one-cycle strobe; w_data is valid this cycle.
- w_data  out  DATA_WIDTH  normalized result.
- normalized_window  out  1  one-cycle strobe when the window slides.
- overflow_err  out  1  sticky; set when a push is dropped.

Behaviour:
- Reset (reset_n low at a core_clk edge): state FILL, count 0, accumulators 0, all outputs 0. This holds in every state, including mid-DIVIDE.
- Clocking: single clock domain, synchronous active-low reset only. No asynchronous paths.
- Window storage: shift buffer with entry 0 the oldest. Centre element is entry WIN_DEPTH/2 (entry 2 by default).

State machine:
- FILL:
  - r_data_valid pushes r_data at index count; count increments.
  - When count reaches WIN_DEPTH, full_flag goes high the next cycle and the state moves to SUMSQ.
- SUMSQ:
  - WIN_DEPTH cycles, one square accumulated per cycle into sum_sq.
  - sum_sq width is 2*DATA_WIDTH + clog2(WIN_DEPTH); it never overflows.
- DIVIDE:
  - 1 setup cycle: denom = K_CONST + (sum_sq >> ALPHA_SHIFT), saturated to 2*DATA_WIDTH bits; dividend = centre << FRAC_BITS.
  - Then DATA_WIDTH+FRAC_BITS restoring-division iterations, one quotient bit per cycle, MSB first.
- OUTPUT:
  - div_out_valid=1 for exactly one cycle.
  - w_data = quotient, saturated to 2^DATA_WIDTH-1 if wider.
  - w_data holds its value until the next OUTPUT.
- SLIDE:
  - Shift the window by one (drop entry 0); count = WIN_DEPTH-1.
  - full_flag=0; normalized_window=1 for this cycle; next state FILL.

Latency (defaults):
- full_flag rises at cycle T.
- div_out_valid at T + WIN_DEPTH + 1 + DATA_WIDTH + FRAC_BITS = T+30.
- normalized_window at T+31.

Boundary conditions:
- Push outside FILL: dropped, overflow_err set (sticky until reset); window contents are unchanged.
- clear_window, any state: next cycle count=0, state FILL, full_flag, div_out_valid and normalized_window all 0. overflow_err and w_data are kept.
- clear_window and r_data_valid in the same cycle: clear wins and the data is dropped. overflow_err is not set.
- First window after reset or clear needs WIN_DEPTH pushes; each subsequent window needs only one push.
- denom >= K_CONST >= 1, so division by zero cannot occur.

Optional Feature:
LRN_BYPASS_EN:
- Defined: adds input port lrn_bypass (1 bit). When lrn_bypass is high at the full_flag rise, SUMSQ and DIVIDE are skipped and OUTPUT follows the next cycle with w_data = centre. lrn_bypass is sampled only at that point.
- Undefined: the port is absent and the full computation is always performed.

Test Plan (defaults):
- Push 0,0,0,0,0 -> full_flag at T; div_out_valid at T+30 with w_data=0; normalized_window at T+31.
- Push 4,4,4,4,4 -> sum_sq=80, denom=7, 1024/7 -> w_data=146.
- Push 0,0,16,0,0 -> denom=18, 4096/18 -> w_data=227. Then push 0 -> window 0,16,0,0,0, centre 0 -> w_data=0 after a single push.
- Push a 6th value while in SUMSQ -> overflow_err=1 and stays 1; the result from the 5 entries already buffered is unchanged.
- Assert reset_n=0 mid-DIVIDE -> next cycle all outputs 0. A new 5-push window then completes normally.
- LRN_BYPASS_EN defined, lrn_bypass=1, push 1,2,3,4,5 -> div_out_valid at T+1 with w_data=3.

Source files
------------

// File: rtl/lrn_window_engine_if.sv
// Pixel-in / result-out bundle for lrn_window_engine.
// lrn_bypass exists only when LRN_BYPASS_EN is defined.
interface lrn_window_engine_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  r_data_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  clear_window;
`ifdef LRN_BYPASS_EN
    logic                  lrn_bypass;
`endif
    logic                  full_flag;
    logic                  div_out_valid;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  normalized_window;
    logic                  overflow_err;

    modport master (
`ifdef LRN_BYPASS_EN
        output lrn_bypass,
`endif
        output r_data_valid, r_data, clear_window,
        input  full_flag, div_out_valid, w_data, normalized_window, overflow_err
    );

    modport slave (
`ifdef LRN_BYPASS_EN
        input  lrn_bypass,
`endif
        input  r_data_valid, r_data, clear_window,
        output full_flag, div_out_valid, w_data, normalized_window, overflow_err
    );
endinterface

// File: rtl/lrn_window_engine.sv
// Cross-channel LRN engine: sliding pixel window, serial sum of squares, restoring divide.
// Optional macro LRN_BYPASS_EN adds lrn_bypass, which returns the centre pixel unnormalised.
module lrn_window_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int WIN_DEPTH   = 5,
    parameter int FRAC_BITS   = 8,
    parameter int K_CONST     = 2,
    parameter int ALPHA_SHIFT = 4
) (
    input  logic core_clk,
    input  logic reset_n,
    lrn_window_engine_if.slave bus
);
    localparam int QW     = DATA_WIDTH + FRAC_BITS;
    localparam int DW2    = 2 * DATA_WIDTH;
    localparam int SW     = DW2 + $clog2(WIN_DEPTH);
    localparam int CW     = $clog2(WIN_DEPTH + 1);
    localparam int SPW    = $clog2(QW + 1);
    localparam int CENTRE = WIN_DEPTH / 2;

    typedef enum logic [2:0] {
        S_FILL,
        S_SUMSQ,
        S_DIVIDE,
        S_OUTPUT,
        S_SLIDE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_count;
    logic [SPW-1:0]        r_step;
    logic [SW-1:0]         r_sum;
    logic [DW2-1:0]        r_denom;
    logic [DW2-1:0]        r_rem;
    logic [QW-1:0]         r_dividend;
    logic [QW-1:0]         r_quot;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_win [WIN_DEPTH];
    logic [DATA_WIDTH-1:0] w_sel;
    logic [DATA_WIDTH-1:0] w_centre;
    logic [DW2-1:0]        w_sq;
    logic [SW-1:0]         w_sum_sh;
    logic [SW:0]           w_denom_full;
    logic [DW2:0]          w_rem_sh;
    logic [DW2:0]          w_rem_sub;
    logic                  w_ge;
    logic [QW-1:0]         w_quot_next;
    logic [DATA_WIDTH-1:0] w_quot_sat;
    logic                  w_push_ok;
    logic                  w_push_drop;
    logic                  w_slide;
    logic                  w_bypass;
    logic                  w_unused;

    assign w_push_ok   = bus.r_data_valid && !bus.clear_window && (r_state == S_FILL);
    assign w_push_drop = bus.r_data_valid && !bus.clear_window && (r_state != S_FILL);
    assign w_slide     = (r_state == S_SLIDE) && !bus.clear_window;

`ifdef LRN_BYPASS_EN
    assign w_bypass = bus.lrn_bypass && (r_state == S_SUMSQ) && (r_step == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Entry 0 is the oldest pixel; a slide moves every entry one place towards 0.
    generate
        for (genvar gi = 0; gi < WIN_DEPTH; gi++) begin : g_win
            logic [DATA_WIDTH-1:0] r_entry;
            logic [DATA_WIDTH-1:0] w_shift_in;

            if (gi < WIN_DEPTH - 1) begin : g_mid
                assign w_shift_in = w_win[gi+1];
            end else begin : g_top
                assign w_shift_in = r_entry;
            end

            always_ff @(posedge core_clk) begin
                if (!reset_n) begin
                    r_entry <= '0;
                end else if (w_push_ok && (r_count == CW'(gi))) begin
                    r_entry <= bus.r_data;
                end else if (w_slide) begin
                    r_entry <= w_shift_in;
                end
            end

            assign w_win[gi] = r_entry;
        end
    endgenerate

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < WIN_DEPTH; i++) begin
            if (r_step == SPW'(i)) begin
                w_sel = w_win[i];
            end
        end
    end

    assign w_centre     = w_win[CENTRE];
    assign w_sq         = DW2'(w_sel) * DW2'(w_sel);
    assign w_sum_sh     = r_sum >> ALPHA_SHIFT;
    assign w_denom_full = {1'b0, w_sum_sh} + (SW + 1)'(K_CONST);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign w_rem_sh    = {r_rem, r_dividend[QW-1]};
    assign w_rem_sub   = w_rem_sh - {1'b0, r_denom};
    assign w_ge        = (w_rem_sh >= {1'b0, r_denom});
    assign w_quot_next = {r_quot[QW-2:0], w_ge};
    assign w_quot_sat  = (|w_quot_next[QW-1:DATA_WIDTH]) ? '1 : w_quot_next[DATA_WIDTH-1:0];
    assign w_unused    = &{1'b0, w_rem_sh[DW2], w_rem_sub[DW2], r_quot[QW-1]};

    always_ff @(posedge core_clk) begin
        if (!reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.clear_window) begin
            w_state_next = S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_push_ok && (r_count == CW'(WIN_DEPTH - 1))) begin
                        w_state_next = S_SUMSQ;
                    end
                end
                S_SUMSQ: begin
                    if (w_bypass) begin
                        w_state_next = S_OUTPUT;
                    end else if (r_step == SPW'(WIN_DEPTH - 1)) begin
                        w_state_next = S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (r_step == SPW'(QW)) begin
                        w_state_next = S_OUTPUT;
                    end
                end
                S_OUTPUT: w_state_next = S_SLIDE;
                S_SLIDE:  w_state_next = S_FILL;
                default:  w_state_next = S_FILL;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_step     <= '0;
            r_sum      <= '0;
            r_denom    <= '0;
            r_rem      <= '0;
            r_dividend <= '0;
            r_quot     <= '0;
            r_wdata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // r_step restarts on every state change, so it counts cycles within a state.
            r_step <= (w_state_next != r_state) ? '0 : r_step + 1'b1;
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
            if (bus.clear_window) begin
                r_count <= '0;
            end else begin
                if (w_push_ok) begin
                    r_count <= r_count + 1'b1;
                end else if (r_state == S_SLIDE) begin
                    r_count <= CW'(WIN_DEPTH - 1);
                end
                case (r_state)
                    S_SUMSQ: begin
                        r_sum <= ((r_step == '0) ? '0 : r_sum) + SW'(w_sq);
                        if (w_bypass) begin
                            r_wdata <= w_centre;
                        end
                    end
                    S_DIVIDE: begin
                        if (r_step == '0) begin
                            r_denom    <= (|w_denom_full[SW:DW2]) ? '1 : w_denom_full[DW2-1:0];
                            r_dividend <= {w_centre, {FRAC_BITS{1'b0}}};
                            r_rem      <= '0;
                            r_quot     <= '0;
                        end else begin
                            r_rem      <= w_ge ? w_rem_sub[DW2-1:0] : w_rem_sh[DW2-1:0];
                            r_dividend <= {r_dividend[QW-2:0], 1'b0};
                            r_quot     <= w_quot_next;
                            if (r_step == SPW'(QW)) begin
                                r_wdata <= w_quot_sat;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.full_flag         = (r_state == S_SUMSQ) || (r_state == S_DIVIDE) || (r_state == S_OUTPUT);
    assign bus.div_out_valid     = (r_state == S_OUTPUT);
    assign bus.normalized_window = (r_state == S_SLIDE);
    assign bus.w_data            = r_wdata;
    assign bus.overflow_err      = r_overflow;
endmodule

// File: tb/tb_lrn_window_engine.sv
// Scoreboard bench for lrn_window_engine: a queue-based window model predicts each LRN result,
// a monitor pops and compares whenever div_out_valid fires.
module tb_lrn_window_engine;
    localparam int DW  = 16;
    localparam int WD  = 5;
    localparam int FB  = 8;
    localparam int KC  = 2;
    localparam int AS  = 4;
    localparam int LAT = WD + 1 + DW + FB;

    logic core_clk = 1'b0;
    logic reset_n  = 1'b0;
    always #5 core_clk = ~core_clk;

    lrn_window_engine_if #(.DATA_WIDTH(DW)) bus ();

    lrn_window_engine #(
        .DATA_WIDTH (DW),
        .WIN_DEPTH  (WD),
        .FRAC_BITS  (FB),
        .K_CONST    (KC),
        .ALPHA_SHIFT(AS)
    ) dut (
        .core_clk(core_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int  n_cmp   = 0;
    int  n_bad   = 0;
    int  exp_q[$];
    int  win[$];
    int  last_w  = 0;
    int  exp_lat = LAT;
    int  cycle   = 0;
    int  t_full  = -1000;
    int  t_div   = -1000;
    int  n_txn   = 0;
    bit  byp_on  = 1'b0;
    logic prev_full = 1'b0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // LRN straight from the definition: centre * 2^FB / (K + sum(x^2) / 2^AS).
    function automatic int ref_lrn(int w[$], bit byp);
        longint sumsq;
        longint denom;
        longint q;
        if (byp) return w[WD/2];
        sumsq = 0;
        foreach (w[i]) sumsq += longint'(w[i]) * longint'(w[i]);
        denom = KC + (sumsq / (64'd1 << AS));
        if (denom > 64'hFFFF_FFFF) denom = 64'hFFFF_FFFF;
        q = (longint'(w[WD/2]) * (64'd1 << FB)) / denom;
        if (q > 65535) q = 65535;
        return int'(q);
    endfunction

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 65535));
            1:       return int'($urandom_range(0, 255));
            2:       return int'($urandom_range(0, 15));
            default: return 0;
        endcase
    endfunction

    // Monitor: timing of full_flag -> div_out_valid -> normalized_window, and result values.
    initial begin
        forever begin
            @(negedge core_clk);
            cycle++;
            if (bus.full_flag && !prev_full) t_full = cycle;
            prev_full = bus.full_flag;
            if (bus.div_out_valid) begin
                t_div = cycle;
                check("latency_full_to_div", longint'(cycle - t_full), longint'(exp_lat));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got w_data=%0d, expected no output", bus.w_data);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    n_txn++;
                    $display("txn %0d: cycle %0d w_data=%0d expected=%0d", n_txn, cycle, bus.w_data, e);
                    check("w_data", longint'(bus.w_data), longint'(e));
                end
                last_w = int'(bus.w_data);
            end
            if (bus.normalized_window) begin
                check("latency_div_to_slide", longint'(cycle - t_div), 64'd1);
            end
        end
    end

    task automatic push(int v);
        bus.r_data_valid = 1'b1;
        bus.r_data       = DW'(v);
        @(negedge core_clk);
        bus.r_data_valid = 1'b0;
        win.push_back(v);
        if (win.size() == WD) exp_q.push_back(ref_lrn(win, byp_on));
    endtask

    task automatic wait_slide();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.normalized_window) begin
                seen = 1'b1;
                break;
            end
            @(negedge core_clk);
        end
        check("slide_seen", longint'(seen), 64'd1);
        if (seen) begin
            void'(win.pop_front());
            @(negedge core_clk);
        end
    endtask

    task automatic wait_full();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.full_flag) begin
                seen = 1'b1;
                break;
            end
            @(negedge core_clk);
        end
        check("full_seen", longint'(seen), 64'd1);
    endtask

    task automatic clear_pulse(bit with_push);
        bus.clear_window = 1'b1;
        if (with_push) begin
            bus.r_data_valid = 1'b1;
            bus.r_data       = 16'd999;
        end
        @(negedge core_clk);
        bus.clear_window = 1'b0;
        bus.r_data_valid = 1'b0;
        win.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(string tag, int w_exp, int ovf_exp);
        check({tag, "_full_flag"}, longint'(bus.full_flag), 64'd0);
        check({tag, "_div_out_valid"}, longint'(bus.div_out_valid), 64'd0);
        check({tag, "_normalized_window"}, longint'(bus.normalized_window), 64'd0);
        check({tag, "_overflow_err"}, longint'(bus.overflow_err), longint'(ovf_exp));
        check({tag, "_w_data"}, longint'(bus.w_data), longint'(w_exp));
    endtask

    initial begin
        bus.r_data_valid = 1'b0;
        bus.r_data       = '0;
        bus.clear_window = 1'b0;
`ifdef LRN_BYPASS_EN
        bus.lrn_bypass   = 1'b0;
`endif
        repeat (3) @(negedge core_clk);
        check_idle_outputs("reset", 0, 0);
        reset_n = 1'b1;
        @(negedge core_clk);

        // All-zero window.
        for (int i = 0; i < WD; i++) push(0);
        wait_slide();

        // Clear with a simultaneous push: push dropped without flagging overflow.
        clear_pulse(1'b1);
        check("clear_push_overflow", longint'(bus.overflow_err), 64'd0);
        check("clear_push_full", longint'(bus.full_flag), 64'd0);

        for (int i = 0; i < WD; i++) push(4);
        wait_slide();

        clear_pulse(1'b0);
        push(0); push(0); push(16); push(0); push(0);
        wait_slide();
        push(0);
        wait_slide();

        // Extra push during SUMSQ is dropped and latches overflow_err.
        clear_pulse(1'b0);
        push(100); push(200); push(300); push(400); push(500);
        wait_full();
        bus.r_data_valid = 1'b1;
        bus.r_data       = 16'd12345;
        @(negedge core_clk);
        bus.r_data_valid = 1'b0;
        repeat (3) @(negedge core_clk);
        check("overflow_set", longint'(bus.overflow_err), 64'd1);
        wait_slide();
        check("overflow_sticky", longint'(bus.overflow_err), 64'd1);

        // Clear mid-computation: no result, overflow_err and w_data retained.
        push(rand_val());
        wait_full();
        repeat (8) @(negedge core_clk);
        clear_pulse(1'b0);
        check_idle_outputs("clear_mid", last_w, 1);
        repeat (40) @(negedge core_clk);
        for (int i = 0; i < WD; i++) push(rand_val());
        wait_slide();

        // Reset mid-DIVIDE.
        push(rand_val());
        wait_full();
        repeat (12) @(negedge core_clk);
        reset_n = 1'b0;
        @(negedge core_clk);
        reset_n = 1'b1;
        exp_q.delete();
        win.delete();
        last_w = 0;
        check_idle_outputs("reset_mid", 0, 0);
        @(negedge core_clk);
        for (int i = 0; i < WD; i++) push(int'($urandom_range(1, 40)));
        wait_slide();

        // Randomised stream: one push per window with idle gaps.
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge core_clk);
            push(rand_val());
            wait_slide();
        end

`ifdef LRN_BYPASS_EN
        clear_pulse(1'b0);
        byp_on         = 1'b1;
        exp_lat        = 1;
        bus.lrn_bypass = 1'b1;
        for (int i = 1; i <= WD; i++) push(i);
        wait_slide();
        bus.lrn_bypass = 1'b0;
        byp_on         = 1'b0;
        exp_lat        = LAT;
        push(7);
        wait_slide();
`endif

        repeat (5) @(negedge core_clk);
        check("pending_expected", longint'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout at cycle %0d, expected bench completion", cycle);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
